// File: rtl/icache_direct.sv
// Direct-mapped read-only instruction cache: 64-byte lines filled as eight 64-bit bus beats,
// one 32-bit word returned per fetch request, whole-cache flush.
module icache_direct #(
  parameter int BUS_DATA_WIDTH = 64,
  parameter int BUS_TAG_WIDTH  = 13,
  parameter int SETS           = 64
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      ic_req,
  input  logic [57:0]               ic_line_addr,
  input  logic [3:0]                ic_word_select,
  output logic                      ic_ack,
  output logic [31:0]               ic_data_out,
  input  logic                      flush,
  output logic                      bus_reqcyc,
  output logic [63:0]               bus_req,
  output logic [BUS_TAG_WIDTH-1:0]  bus_reqtag,
  input  logic                      bus_reqack,
  input  logic                      bus_respcyc,
  input  logic [BUS_DATA_WIDTH-1:0] bus_resp,
  input  logic [BUS_TAG_WIDTH-1:0]  bus_resptag,
  output logic                      bus_respack
);

  localparam int INDEX_BITS = $clog2(SETS);
  localparam int TAG_BITS   = 58 - INDEX_BITS;
  localparam logic [BUS_TAG_WIDTH-1:0] READ_TAG = BUS_TAG_WIDTH'(13'h1400);

  typedef enum logic [1:0] {IDLE, REQ, FILL, RESP} state_t;

  state_t                  state_q, state_d;
  logic [SETS-1:0]         valid_q, valid_d;
  logic                    flush_pending_q, flush_pending_d;
  logic [2:0]              cnt_q, cnt_d;
  logic [57:0]             addr_q, addr_d;
  logic [3:0]              word_q, word_d;
  logic [31:0]             data_out_q, data_out_d;
  logic [15:0][31:0]       line_q, line_d;

  logic [15:0][31:0]       data_mem [SETS];
  logic [TAG_BITS-1:0]     tag_mem  [SETS];
  logic                    fill_we;

  logic [INDEX_BITS-1:0]   req_index, fill_index;
  logic [TAG_BITS-1:0]     req_tag, fill_tag;
  logic                    hit, beat_ok;

  assign req_index  = ic_line_addr[INDEX_BITS-1:0];
  assign req_tag    = ic_line_addr[57:INDEX_BITS];
  assign fill_index = addr_q[INDEX_BITS-1:0];
  assign fill_tag   = addr_q[57:INDEX_BITS];
  assign hit        = valid_q[req_index] && (tag_mem[req_index] == req_tag);
  assign beat_ok    = bus_respcyc && (bus_resptag == READ_TAG);

  assign ic_ack      = (state_q == RESP);
  assign ic_data_out = data_out_q;
  assign bus_reqcyc  = (state_q == REQ);
  assign bus_req     = {addr_q, 6'b0};
  assign bus_reqtag  = READ_TAG;

  always_comb begin
    state_d         = state_q;
    valid_d         = valid_q;
    flush_pending_d = flush_pending_q;
    cnt_d           = cnt_q;
    addr_d          = addr_q;
    word_d          = word_q;
    data_out_d      = data_out_q;
    line_d          = line_q;
    fill_we         = 1'b0;
    bus_respack     = 1'b0;

    case (state_q)
      IDLE: begin
        bus_respack = bus_respcyc;
        if (flush) begin
          valid_d = '0;
        end else if (ic_req) begin
          if (hit) begin
            data_out_d = data_mem[req_index][ic_word_select];
            state_d    = RESP;
          end else begin
            addr_d  = ic_line_addr;
            word_d  = ic_word_select;
            state_d = REQ;
          end
        end
      end
      REQ: begin
        bus_respack = bus_respcyc;
        if (flush) flush_pending_d = 1'b1;
        if (bus_reqack) begin
          cnt_d   = '0;
          state_d = FILL;
        end
      end
      FILL: begin
        if (flush) flush_pending_d = 1'b1;
        if (beat_ok) begin
          bus_respack             = 1'b1;
          line_d[{cnt_q, 1'b0}]   = bus_resp[31:0];
          line_d[{cnt_q, 1'b1}]   = bus_resp[63:32];
          cnt_d                   = cnt_q + 3'd1;
          // last beat goes straight into the array alongside the buffered words
          if (cnt_q == 3'd7) begin
            fill_we             = 1'b1;
            valid_d[fill_index] = 1'b1;
            data_out_d          = line_d[word_q];
            state_d             = RESP;
          end
        end
      end
      RESP: begin
        bus_respack = bus_respcyc;
        state_d     = IDLE;
        if (flush_pending_q || flush) begin
          valid_d         = '0;
          flush_pending_d = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q         <= IDLE;
      valid_q         <= '0;
      flush_pending_q <= 1'b0;
      cnt_q           <= '0;
      addr_q          <= '0;
      word_q          <= '0;
      data_out_q      <= '0;
    end else begin
      state_q         <= state_d;
      valid_q         <= valid_d;
      flush_pending_q <= flush_pending_d;
      cnt_q           <= cnt_d;
      addr_q          <= addr_d;
      word_q          <= word_d;
      data_out_q      <= data_out_d;
    end
  end

  always_ff @(posedge clk) begin
    line_q <= line_d;
    if (fill_we) begin
      data_mem[fill_index] <= line_d;
      tag_mem[fill_index]  <= fill_tag;
    end
  end

endmodule

// File: tb/tb_icache_direct.sv
// Directed self-checking bench for icache_direct.
module tb_icache_direct;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        ic_req = 1'b0;
  logic [57:0] ic_line_addr = '0;
  logic [3:0]  ic_word_select = '0;
  logic        ic_ack;
  logic [31:0] ic_data_out;
  logic        flush = 1'b0;
  logic        bus_reqcyc;
  logic [63:0] bus_req;
  logic [12:0] bus_reqtag;
  logic        bus_reqack = 1'b0;
  logic        bus_respcyc = 1'b0;
  logic [63:0] bus_resp = '0;
  logic [12:0] bus_resptag = '0;
  logic        bus_respack;

  int errors = 0;
  int checks = 0;

  icache_direct #(.BUS_DATA_WIDTH(64), .BUS_TAG_WIDTH(13), .SETS(64)) dut (
    .clk(clk), .reset(reset),
    .ic_req(ic_req), .ic_line_addr(ic_line_addr), .ic_word_select(ic_word_select),
    .ic_ack(ic_ack), .ic_data_out(ic_data_out), .flush(flush),
    .bus_reqcyc(bus_reqcyc), .bus_req(bus_req), .bus_reqtag(bus_reqtag),
    .bus_reqack(bus_reqack), .bus_respcyc(bus_respcyc), .bus_resp(bus_resp),
    .bus_resptag(bus_resptag), .bus_respack(bus_respack)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [63:0] beat(input logic [31:0] base, input int k);
    logic [31:0] lo, hi;
    lo = base + 32'(2 * k);
    hi = base + 32'(2 * k + 1);
    return {hi, lo};
  endfunction

  // Drives one miss transaction end to end and reports what the DUT did.
  task automatic serve_miss(
    input  logic [57:0] line, input logic [3:0] word, input logic [31:0] base,
    input  int ack_delay, input int gap, input bit foreign, input int flush_beat, input bit pre_flush,
    output bit early_busy, output bit reqcyc_seen, output logic [63:0] addr, output logic [12:0] tag,
    output bit reqcyc_held, output bit reqcyc_dropped, output int bad_acks, output bit foreign_acked,
    output bit ack_ok, output logic [31:0] data, output bit ack_single);
    early_busy = 1'b0;
    @(negedge clk);
    ic_req = 1'b1; ic_line_addr = line; ic_word_select = word; flush = pre_flush;
    if (pre_flush) begin
      @(negedge clk);
      flush = 1'b0;
      #1 early_busy = ic_ack | bus_reqcyc;
    end
    @(negedge clk);
    #1;
    reqcyc_seen = bus_reqcyc; addr = bus_req; tag = bus_reqtag; reqcyc_held = 1'b1;
    repeat (ack_delay) begin
      @(negedge clk);
      #1 if (!bus_reqcyc) reqcyc_held = 1'b0;
    end
    @(negedge clk);
    bus_reqack = 1'b1;
    #1 if (!bus_reqcyc) reqcyc_held = 1'b0;
    @(negedge clk);
    bus_reqack = 1'b0;
    #1 reqcyc_dropped = !bus_reqcyc;
    bad_acks = 0; foreign_acked = 1'b0;
    for (int k = 0; k < 8; k++) begin
      for (int g = 0; g < gap; g++) begin
        bus_respcyc = 1'b0;
        @(negedge clk);
      end
      if (foreign && k == 4) begin
        bus_respcyc = 1'b1; bus_resptag = 13'h0ABC; bus_resp = 64'hDEAD_BEEF_0BAD_F00D;
        #1 if (bus_respack) foreign_acked = 1'b1;
        @(negedge clk);
      end
      if (flush_beat == k) flush = 1'b1;
      bus_respcyc = 1'b1; bus_resptag = 13'h1400; bus_resp = beat(base, k);
      #1 if (!bus_respack) bad_acks++;
      @(negedge clk);
      flush = 1'b0;
    end
    bus_respcyc = 1'b0; ic_req = 1'b0;
    #1 ack_ok = ic_ack; data = ic_data_out;
    @(negedge clk);
    #1 ack_single = !ic_ack && (ic_data_out == data);
  endtask

  task automatic test_reset;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    #1;
    checks++; if (ic_ack !== 1'b0) begin errors++; $display("FAIL reset_ack: got %b want 0", ic_ack); end
    checks++; if (ic_data_out !== 32'h0) begin errors++; $display("FAIL reset_data: got %h want 0", ic_data_out); end
    checks++; if (bus_reqcyc !== 1'b0) begin errors++; $display("FAIL reset_reqcyc: got %b want 0", bus_reqcyc); end
    checks++; if (bus_req !== 64'h0) begin errors++; $display("FAIL reset_busreq: got %h want 0", bus_req); end
    checks++; if (bus_respack !== 1'b0) begin errors++; $display("FAIL reset_respack: got %b want 0", bus_respack); end
    bus_respcyc = 1'b1;
    #1;
    checks++; if (bus_respack !== 1'b1) begin errors++; $display("FAIL idle_stray_ack: got %b want 1", bus_respack); end
    bus_respcyc = 1'b0;
  endtask

  task automatic test_cold_miss;
    bit eb, rs, rh, rd, fa, ao, as_; logic [63:0] a; logic [12:0] t; int ba; logic [31:0] d;
    serve_miss(58'h1, 4'd3, 32'h0, 2, 0, 1'b0, -1, 1'b0, eb, rs, a, t, rh, rd, ba, fa, ao, d, as_);
    checks++; if (rs !== 1'b1) begin errors++; $display("FAIL cold_reqcyc: got %b want 1", rs); end
    checks++; if (a !== 64'h40) begin errors++; $display("FAIL cold_busreq: got %h want 40", a); end
    checks++; if (t !== 13'h1400) begin errors++; $display("FAIL cold_reqtag: got %h want 1400", t); end
    checks++; if (rh !== 1'b1) begin errors++; $display("FAIL cold_reqcyc_held: got %b want 1", rh); end
    checks++; if (rd !== 1'b1) begin errors++; $display("FAIL cold_reqcyc_drop: got %b want 1", rd); end
    checks++; if (ba !== 0) begin errors++; $display("FAIL cold_beat_acks: missing %0d want 0", ba); end
    checks++; if (ao !== 1'b1) begin errors++; $display("FAIL cold_ack: got %b want 1", ao); end
    checks++; if (d !== 32'd3) begin errors++; $display("FAIL cold_data: got %h want 3", d); end
    checks++; if (as_ !== 1'b1) begin errors++; $display("FAIL cold_ack_single_hold: got %b want 1", as_); end
  endtask

  task automatic test_hit;
    @(negedge clk);
    ic_req = 1'b1; ic_line_addr = 58'h1; ic_word_select = 4'd14;
    @(negedge clk);
    #1;
    checks++; if (ic_ack !== 1'b1) begin errors++; $display("FAIL hit_ack: got %b want 1", ic_ack); end
    checks++; if (ic_data_out !== 32'd14) begin errors++; $display("FAIL hit_data: got %h want e", ic_data_out); end
    checks++; if (bus_reqcyc !== 1'b0) begin errors++; $display("FAIL hit_no_bus: got %b want 0", bus_reqcyc); end
    ic_word_select = 4'd2;
    @(negedge clk);
    #1;
    checks++; if (ic_ack !== 1'b0) begin errors++; $display("FAIL hit_ack_gap: got %b want 0", ic_ack); end
    @(negedge clk);
    #1;
    checks++; if (ic_ack !== 1'b1 || ic_data_out !== 32'd2) begin
      errors++; $display("FAIL hit_back_to_back: got ack=%b data=%h want ack=1 data=2", ic_ack, ic_data_out);
    end
    ic_req = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_conflict;
    bit eb, rs, rh, rd, fa, ao, as_; logic [63:0] a; logic [12:0] t; int ba; logic [31:0] d;
    serve_miss(58'h41, 4'd5, 32'h100, 1, 0, 1'b0, -1, 1'b0, eb, rs, a, t, rh, rd, ba, fa, ao, d, as_);
    checks++; if (rs !== 1'b1 || a !== 64'h1040) begin errors++; $display("FAIL conflict_first_miss: got reqcyc=%b addr=%h want 1/1040", rs, a); end
    checks++; if (ao !== 1'b1 || d !== 32'h105) begin errors++; $display("FAIL conflict_first_data: got ack=%b data=%h want 1/105", ao, d); end
    serve_miss(58'h1, 4'd3, 32'h0, 0, 0, 1'b0, -1, 1'b0, eb, rs, a, t, rh, rd, ba, fa, ao, d, as_);
    checks++; if (rs !== 1'b1 || a !== 64'h40) begin errors++; $display("FAIL conflict_refill_miss: got reqcyc=%b addr=%h want 1/40", rs, a); end
    checks++; if (ao !== 1'b1 || d !== 32'd3) begin errors++; $display("FAIL conflict_refill_data: got ack=%b data=%h want 1/3", ao, d); end
  endtask

  task automatic test_flush;
    bit eb, rs, rh, rd, fa, ao, as_; logic [63:0] a; logic [12:0] t; int ba; logic [31:0] d;
    serve_miss(58'h4, 4'd6, 32'h400, 0, 0, 1'b0, 3, 1'b0, eb, rs, a, t, rh, rd, ba, fa, ao, d, as_);
    checks++; if (ao !== 1'b1 || d !== 32'h406) begin errors++; $display("FAIL flush_fill_ack: got ack=%b data=%h want 1/406", ao, d); end
    serve_miss(58'h4, 4'd6, 32'h400, 0, 0, 1'b0, -1, 1'b0, eb, rs, a, t, rh, rd, ba, fa, ao, d, as_);
    checks++; if (rs !== 1'b1) begin errors++; $display("FAIL flush_rereq_miss: got reqcyc=%b want 1", rs); end
    checks++; if (d !== 32'h406) begin errors++; $display("FAIL flush_rereq_data: got %h want 406", d); end
    serve_miss(58'h4, 4'd0, 32'h400, 0, 0, 1'b0, -1, 1'b1, eb, rs, a, t, rh, rd, ba, fa, ao, d, as_);
    checks++; if (eb !== 1'b0) begin errors++; $display("FAIL flush_wins_over_req: got busy=%b want 0", eb); end
    checks++; if (rs !== 1'b1) begin errors++; $display("FAIL flush_req_then_miss: got reqcyc=%b want 1", rs); end
    checks++; if (ao !== 1'b1 || d !== 32'h400) begin errors++; $display("FAIL flush_req_data: got ack=%b data=%h want 1/400", ao, d); end
  endtask

  task automatic test_foreign_gapped;
    bit eb, rs, rh, rd, fa, ao, as_; logic [63:0] a; logic [12:0] t; int ba; logic [31:0] d;
    serve_miss(58'h2, 4'd9, 32'h200, 3, 2, 1'b1, -1, 1'b0, eb, rs, a, t, rh, rd, ba, fa, ao, d, as_);
    checks++; if (fa !== 1'b0) begin errors++; $display("FAIL foreign_unacked: got ack=%b want 0", fa); end
    checks++; if (ba !== 0) begin errors++; $display("FAIL gapped_beat_acks: missing %0d want 0", ba); end
    checks++; if (ao !== 1'b1 || d !== 32'h209) begin errors++; $display("FAIL foreign_data: got ack=%b data=%h want 1/209", ao, d); end
    checks++; if (rh !== 1'b1) begin errors++; $display("FAIL slow_ack_reqcyc_held: got %b want 1", rh); end
  endtask

  task automatic test_reset_mid_fill;
    bit eb, rs, rh, rd, fa, ao, as_; logic [63:0] a; logic [12:0] t; int ba; logic [31:0] d;
    int stray_missing = 0;
    @(negedge clk);
    ic_req = 1'b1; ic_line_addr = 58'h3; ic_word_select = 4'd1;
    @(negedge clk);
    bus_reqack = 1'b1;
    @(negedge clk);
    bus_reqack = 1'b0;
    for (int k = 0; k < 5; k++) begin
      bus_respcyc = 1'b1; bus_resptag = 13'h1400; bus_resp = beat(32'h300, k);
      @(negedge clk);
    end
    bus_respcyc = 1'b0; ic_req = 1'b0; reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    #1;
    checks++; if (bus_reqcyc !== 1'b0 || ic_ack !== 1'b0 || ic_data_out !== 32'h0) begin
      errors++; $display("FAIL midreset_idle: got reqcyc=%b ack=%b data=%h want 0/0/0", bus_reqcyc, ic_ack, ic_data_out);
    end
    for (int k = 5; k < 8; k++) begin
      bus_respcyc = 1'b1; bus_resptag = 13'h1400; bus_resp = beat(32'h300, k);
      #1 if (!bus_respack) stray_missing++;
      @(negedge clk);
    end
    bus_respcyc = 1'b0;
    #1;
    checks++; if (stray_missing !== 0 || ic_ack !== 1'b0) begin
      errors++; $display("FAIL midreset_stray_drain: got unacked=%0d ack=%b want 0/0", stray_missing, ic_ack);
    end
    serve_miss(58'h3, 4'd1, 32'h300, 0, 0, 1'b0, -1, 1'b0, eb, rs, a, t, rh, rd, ba, fa, ao, d, as_);
    checks++; if (rs !== 1'b1 || a !== 64'hC0) begin errors++; $display("FAIL midreset_fresh_miss: got reqcyc=%b addr=%h want 1/c0", rs, a); end
    checks++; if (ao !== 1'b1 || d !== 32'h301) begin errors++; $display("FAIL midreset_data: got ack=%b data=%h want 1/301", ao, d); end
  endtask

  initial begin
    test_reset();
    test_cold_miss();
    test_hit();
    test_conflict();
    test_flush();
    test_foreign_gapped();
    test_reset_mid_fill();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/icache_direct.md
# icache_direct

Direct-mapped, read-only instruction cache between the instruction fetch stage and the memory bus. It serves one 32-bit instruction word per request over a req/ack handshake. On a miss it fetches a full 64-byte line as eight 64-bit bus beats, installs the line, then returns the requested word. It supports a whole-cache invalidate for self-modifying-code and context-switch flushes.

## Interface
- BUS_DATA_WIDTH, 64, bus beat width; only 64 is supported.
- BUS_TAG_WIDTH, 13, bus transaction tag width.
- SETS, 64, number of lines; power of two. INDEX_BITS = log2(SETS).
- clk  in  1  clock.
- reset  in  1  reset, synchronous, active-high.
- ic_req  in  1  fetch request; held with address stable until ic_ack.
- ic_line_addr  in  58  PC[63:6].
- ic_word_select  in  4  PC[5:2].
- ic_ack  out  1  one-cycle pulse: ic_data_out is valid.
- ic_data_out  out  32  instruction word; holds its value until the next ic_ack.
- flush  in  1  invalidate all lines (one-cycle pulse).
- bus_reqcyc  out  1  bus read request valid.
- bus_req  out  64  byte address {ic_line_addr, 6'b0}.
- bus_reqtag  out  BUS_TAG_WIDTH  constant 13'h1400 (READ, memory).
- bus_reqack  in  1  bus accepted the request.
- bus_respcyc  in  1  response beat valid.
- bus_resp  in  64  response beat data.
- bus_resptag  in  BUS_TAG_WIDTH  response tag.
- bus_respack  out  1  beat consumed; combinational, asserted the same cycle as the accepted beat.

## Operation
- Address split:
  - index = ic_line_addr[INDEX_BITS-1:0]
  - tag = ic_line_addr[57:INDEX_BITS]
- Storage per set: valid bit, tag, and 16 32-bit words. Only the valid bits are reset.
- Hit condition: valid[index] && tag match.
- States: IDLE, REQ, FILL, RESP.
  - **IDLE**, ic_req=1, flush=0:
    - On a hit, latch word[ic_word_select] into ic_data_out and go to RESP.
    - On a miss, latch the address and go to REQ.
  - **REQ**: bus_reqcyc=1 with bus_req and bus_reqtag stable. When bus_reqack=1, go to FILL with beat counter = 0.
  - **FILL**: accept a beat only when bus_respcyc=1 and bus_resptag=13'h1400.
    - Accepted beat k writes line-buffer words 2k (bus_resp[31:0]) and 2k+1 (bus_resp[63:32]), then increments the 3-bit counter.
    - On beat 7, write the buffer into the data array, set tag and valid, latch the requested word into ic_data_out, and go to RESP.
    - Beats with any other tag are neither acked nor used.
  - **RESP**: ic_ack=1 for exactly one cycle, then go to IDLE. ic_req is ignored in RESP.
- Flush:
  - In IDLE, flush clears all valid bits that cycle. It wins over a simultaneous ic_req, which is evaluated in the next IDLE cycle.
  - In any other state, flush sets flush_pending. flush_pending is applied on the RESP->IDLE edge and invalidates the just-filled line too.
- Stray beats: in IDLE, REQ or RESP, any bus_respcyc is acked (bus_respack=1) and discarded. This drains fills orphaned by reset.

## Timing
- Reset state:
  - state=IDLE, all valid=0, flush_pending=0, counter=0.
  - ic_ack=0, ic_data_out=32'h0.
  - bus_reqcyc=0, bus_req=0, bus_respack=0.
- Hit: ic_req sampled in IDLE at cycle N gives ic_ack at N+1. Next request is accepted at N+2 at the earliest.
- Miss: bus_reqcyc rises at N+1. If bus_reqack arrives at cycle A, FILL begins at A+1. After the 8th accepted beat at cycle M, ic_ack is asserted at M+1.
- Gaps between beats are allowed; FILL waits indefinitely.
- bus_reqcyc stays high until acked, including the ack cycle; it drops in the next cycle.
- Reset mid-operation: reset returns to IDLE next cycle and discards the partial line with valid untouched-cleared. Remaining beats are drained per the stray-beat rule.
- Requests to the same index with a different tag evict the old line. There is no replacement choice.

## Test plan
- **Cold miss.** Reset, then request line 0x1, word 3. Bus acks after 2 cycles and returns beats data = {2k+1, 2k}.
  - Expect bus_req=0x40 and tag 0x1400.
  - Expect ic_data_out=3 and a single-cycle ic_ack one cycle after beat 7.
- **Hit after fill.** Re-request line 0x1, word 14.
  - Expect ic_ack the next cycle with data 14 and no bus activity.
- **Conflict.** Request line 0x41 (same index 1 when SETS=64), then line 0x1.
  - Expect two full bus fills. The second returns the original data.
- **Flush.**
  - Pulse flush during FILL: the ack still arrives, then a re-request misses.
  - Assert flush and ic_req together in IDLE: the request is served one cycle later as a miss.
- **Foreign and gapped beats.** Inject a beat tagged 0x0ABC between beats 3 and 4, plus idle gaps.
  - Expect the foreign beat to be unacked and ignored, and correct final data.
- **Reset mid-fill.** Reset after beat 4, deliver remaining beats 5-7, then request the same line.
  - Expect the stray beats acked and dropped, and a fresh miss with a new bus request.
